// File: rtl/s2mm_axi_write_master.sv
// Stream-to-memory DMA: drains a FWFT FIFO into memory as AXI4 INCR write bursts.
// Bursts are limited by max_beats_i, the remaining length and the next 4 KB boundary.
//   state    | meaning
//   IDLE     | waiting for start_i
//   ISSUE_AW | presenting the burst address
//   SEND_W   | streaming FIFO data for the current burst
//   WAIT_B   | waiting for the write response
//   DONE     | one-cycle completion pulse
module s2mm_axi_write_master #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [AW-1:0]     dst_addr_i,
  input  logic [31:0]       len_bytes_i,
  input  logic [7:0]        max_beats_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DW-1:0]     fifo_rd_data,
  output logic [AW-1:0]     m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DW-1:0]     m_axi_wdata,
  output logic [DW/8-1:0]   m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready
);

  localparam int BPB = DW / 8;
  localparam int SZ  = $clog2(BPB);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE_AW, S_SEND_W, S_WAIT_B, S_DONE} state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [31:0]   beats_left;
  logic [8:0]    burst_q;
  logic [8:0]    beat_q;
  logic [7:0]    maxb_q;
  logic [7:0]    awlen_q;
  logic          err_q;
  logic [1:0]    code_q;

  logic [7:0]    maxb_in;
  logic          misaligned;
  logic [8:0]    first_burst;
  logic [8:0]    first_m1;
  logic [AW-1:0] addr_nxt;
  logic [31:0]   left_nxt;
  logic [8:0]    next_burst;
  logic [8:0]    next_m1;
  logic          last_beat;
  logic          w_hs;

  // Beats allowed by max burst size, remaining length and distance to the 4 KB page end.
  function automatic logic [8:0] calc_burst(input logic [11:0] a_lo, input logic [31:0] left,
                                            input logic [7:0] maxb);
    logic [12:0] to_4k;
    logic [31:0] b;
    to_4k = (13'h1000 - {1'b0, a_lo}) >> SZ;
    b = {24'd0, maxb};
    if (left < b) b = left;
    if ({19'd0, to_4k} < b) b = {19'd0, to_4k};
    return b[8:0];
  endfunction

  always_comb begin
    maxb_in     = (max_beats_i == 8'd0) ? 8'd1 : max_beats_i;
    misaligned  = ((dst_addr_i & AW'(BPB - 1)) != '0) || ((len_bytes_i & 32'(BPB - 1)) != '0);
    first_burst = calc_burst(dst_addr_i[11:0], len_bytes_i >> SZ, maxb_in);
    first_m1    = first_burst - 9'd1;
    addr_nxt    = addr_q + (AW'(burst_q) << SZ);
    left_nxt    = beats_left - 32'(burst_q);
    next_burst  = calc_burst(addr_nxt[11:0], left_nxt, maxb_q);
    next_m1     = next_burst - 9'd1;
    last_beat   = (beat_q == burst_q - 9'd1);
    w_hs        = m_axi_wvalid && m_axi_wready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      beats_left <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      maxb_q     <= 8'd1;
      awlen_q    <= '0;
      err_q      <= 1'b0;
      code_q     <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            err_q  <= 1'b0;
            code_q <= 2'b00;
            if (len_bytes_i == 32'd0) begin
              state <= S_DONE;
            end else if (misaligned) begin
              err_q  <= 1'b1;
              code_q <= 2'b10;
              state  <= S_DONE;
            end else begin
              addr_q     <= dst_addr_i;
              beats_left <= len_bytes_i >> SZ;
              maxb_q     <= maxb_in;
              burst_q    <= first_burst;
              awlen_q    <= first_m1[7:0];
              beat_q     <= '0;
              state      <= S_ISSUE_AW;
            end
          end
        end
        S_ISSUE_AW: begin
          if (m_axi_awready) state <= S_SEND_W;
        end
        S_SEND_W: begin
          if (w_hs) begin
            if (last_beat) begin
              beat_q <= '0;
              state  <= S_WAIT_B;
            end else begin
              beat_q <= beat_q + 9'd1;
            end
          end
        end
        S_WAIT_B: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00) begin
              // Abort: data for later bursts stays in the FIFO.
              err_q  <= 1'b1;
              code_q <= 2'b01;
              state  <= S_DONE;
            end else begin
              addr_q     <= addr_nxt;
              beats_left <= left_nxt;
              if (left_nxt == 32'd0) begin
                state <= S_DONE;
              end else begin
                burst_q <= next_burst;
                awlen_q <= next_m1[7:0];
                state   <= S_ISSUE_AW;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = (state != S_IDLE);
  assign done_o        = (state == S_DONE);
  assign err_o         = err_q;
  assign err_code_o    = code_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (state == S_ISSUE_AW);
  assign m_axi_wdata   = fifo_rd_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state == S_SEND_W) && !fifo_empty;
  assign m_axi_wlast   = (state == S_SEND_W) && last_beat;
  assign fifo_rd_en    = w_hs;
  assign m_axi_bready  = (state == S_WAIT_B);

endmodule

// File: tb/tb_s2mm_axi_write_master.sv
// Bench for s2mm_axi_write_master: FIFO and AXI slave models with random stalls,
// burst list and data order predicted from the address/length/max-beats rules.
module tb_s2mm_axi_write_master;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic [AW-1:0] dst_addr_i = '0;
  logic [31:0] len_bytes_i = '0;
  logic [7:0] max_beats_i = '0;
  logic busy_o, done_o, err_o, fifo_rd_en;
  logic [1:0] err_code_o;
  logic fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize;
  logic [1:0] m_axi_awburst;
  logic m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready;
  logic m_axi_awready = 1'b0;
  logic m_axi_wready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic [1:0] m_axi_bresp = 2'b00;
  logic m_axi_bvalid = 1'b0;

  always #5 clk = ~clk;

  s2mm_axi_write_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .dst_addr_i(dst_addr_i),
    .len_bytes_i(len_bytes_i), .max_beats_i(max_beats_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_code_o(err_code_o), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_data[$];
  logic [39:0] exp_aw[$];
  logic [39:0] aw_e;
  int exp_lens[1024];
  int aw_cnt = 0, b_cnt = 0, w_burst = 0, w_beat = 0, wlast_cnt = 0, b_idx = 0;
  int err_burst = -1, b_owed = 0, done_cnt = 0, stall_pct = 0, gap_pct = 0;
  bit pop_pend = 0, b_hs_pend = 0, prev_aw_stall = 0, prev_w_stall = 0, prev_done = 0, keep;
  logic [AW-1:0] prev_awaddr;
  logic [7:0] prev_awlen;
  logic [DW-1:0] prev_wdata;
  logic prev_wlast;

  // Drive slave/FIFO inputs on the falling edge, then observe what the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; fifo_empty = 1;
      pop_pend = 0; b_hs_pend = 0; b_owed = 0; prev_aw_stall = 0; prev_w_stall = 0; prev_done = 0;
    end else begin
      keep = !fifo_empty && !pop_pend;
      if (pop_pend) begin void'(fifo_q.pop_front()); pop_pend = 0; end
      if (b_hs_pend) begin m_axi_bvalid = 0; m_axi_bresp = 0; b_hs_pend = 0; end
      if (b_owed > 0 && !m_axi_bvalid && int'($urandom_range(99)) >= stall_pct) begin
        m_axi_bvalid = 1;
        m_axi_bresp = (b_idx == err_burst) ? 2'b10 : 2'b00;
      end
      m_axi_awready = (int'($urandom_range(99)) >= stall_pct);
      m_axi_wready = (int'($urandom_range(99)) >= stall_pct);
      if (fifo_q.size() == 0) fifo_empty = 1;
      else if (keep) fifo_empty = 0;
      else fifo_empty = (int'($urandom_range(99)) < gap_pct);
      fifo_rd_data = fifo_empty ? {$urandom, $urandom} : fifo_q[0];
      #1;
      if (rst_n) begin
        if (prev_aw_stall) begin
          check("aw_hold_valid", m_axi_awvalid, 1);
          check("aw_hold_addr", m_axi_awaddr, prev_awaddr);
          check("aw_hold_len", m_axi_awlen, prev_awlen);
        end
        if (m_axi_awvalid && m_axi_awready) begin
          check("aw_one_outstanding", aw_cnt, b_cnt);
          check("aw_size", m_axi_awsize, 3);
          check("aw_burst", m_axi_awburst, 1);
          check("aw_expected", exp_aw.size() != 0, 1);
          if (exp_aw.size() != 0) begin
            aw_e = exp_aw.pop_front();
            check("aw_addr", m_axi_awaddr, aw_e[39:8]);
            check("aw_len", m_axi_awlen, aw_e[7:0]);
          end
          aw_cnt++;
        end
        if (prev_w_stall) begin
          check("w_hold_valid", m_axi_wvalid, 1);
          check("w_hold_data", m_axi_wdata, prev_wdata);
          check("w_hold_last", m_axi_wlast, prev_wlast);
        end
        if (m_axi_wvalid) check("w_valid_no_data", fifo_empty, 0);
        check("pop_is_handshake", fifo_rd_en, m_axi_wvalid && m_axi_wready);
        if (fifo_rd_en) pop_pend = 1;
        if (m_axi_wvalid && m_axi_wready) begin
          check("w_after_aw", w_burst < aw_cnt, 1);
          check("w_expected", exp_data.size() != 0, 1);
          if (exp_data.size() != 0) check("w_data", m_axi_wdata, exp_data.pop_front());
          check("w_strb", m_axi_wstrb, 8'hFF);
          check("w_last", m_axi_wlast, w_beat == exp_lens[w_burst]);
          if (m_axi_wlast) wlast_cnt++;
          if (w_beat == exp_lens[w_burst]) begin
            if (w_burst < 1023) w_burst++;
            w_beat = 0;
            b_owed++;
          end else begin
            w_beat++;
          end
        end
        if (m_axi_bvalid && m_axi_bready) begin
          b_hs_pend = 1; b_owed--; b_idx++; b_cnt++;
        end
        if (done_o) begin
          check("done_one_cycle", prev_done, 0);
          done_cnt++;
        end
        prev_done = done_o;
        prev_aw_stall = m_axi_awvalid && !m_axi_awready;
        prev_awaddr = m_axi_awaddr;
        prev_awlen = m_axi_awlen;
        prev_w_stall = m_axi_wvalid && !m_axi_wready;
        prev_wdata = m_axi_wdata;
        prev_wlast = m_axi_wlast;
      end
    end
  end

  // Reference: split the transfer into bursts from the page/length/max rules and fill the FIFO.
  task automatic prep(input logic [31:0] addr, input logic [31:0] len, input logic [7:0] maxb,
                      input bit fill, output int nb);
    int m, bl, to4k, b;
    logic [31:0] a;
    logic [63:0] d;
    fifo_q.delete(); exp_data.delete(); exp_aw.delete();
    aw_cnt = 0; b_cnt = 0; w_burst = 0; w_beat = 0; wlast_cnt = 0; b_idx = 0;
    nb = 0;
    if (fill) begin
      m = (maxb == 0) ? 1 : int'(maxb);
      a = addr;
      bl = int'(len / 8);
      for (int i = 0; i < bl; i++) begin
        d = {$urandom, $urandom};
        fifo_q.push_back(d);
        exp_data.push_back(d);
      end
      while (bl > 0) begin
        to4k = (4096 - int'(a % 4096)) / 8;
        b = m;
        if (bl < b) b = bl;
        if (to4k < b) b = to4k;
        exp_aw.push_back({a, 8'(b - 1)});
        exp_lens[nb] = b - 1;
        nb++;
        a = a + 32'(b * 8);
        bl -= b;
      end
    end
  endtask

  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] len, input logic [7:0] maxb,
                          input int err_at, input logic [1:0] code, input int stall, input int gap);
    int nb, n_aw, left_exp, d0;
    @(negedge clk);
    stall_pct = stall; gap_pct = gap; err_burst = err_at;
    prep(addr, len, maxb, code != 2'b10, nb);
    n_aw = (code == 2'b01) ? err_at + 1 : nb;
    left_exp = 0;
    if (code == 2'b01) for (int k = n_aw; k < nb; k++) left_exp += exp_lens[k] + 1;
    d0 = done_cnt;
    dst_addr_i = addr; len_bytes_i = len; max_beats_i = maxb; start_i = 1;
    @(negedge clk);
    start_i = 0;
    #2;
    check("busy_after_start", busy_o, 1);
    if (code == 2'b10 || len == 0) check("done_next_cycle", done_o, 1);
    else check("err_cleared_on_start", err_o, 0);
    for (int c = 0; c < 20000 && done_cnt == d0; c++) begin @(negedge clk); #2; end
    check("done_seen", done_cnt > d0, 1);
    check("err", err_o, code != 2'b00);
    check("err_code", err_code_o, code);
    check("aw_count", aw_cnt, n_aw);
    check("b_count", b_cnt, n_aw);
    check("wlast_count", wlast_cnt, n_aw);
    check("fifo_left", fifo_q.size(), left_exp);
    @(negedge clk); #2;
    check("idle_busy", busy_o, 0);
    check("idle_done", done_o, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_code", err_code_o, 0);
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_awaddr", m_axi_awaddr, 0);
    check("rst_awlen", m_axi_awlen, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_wlast", m_axi_wlast, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_rd_en", fifo_rd_en, 0);
  endtask

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs();
    check("const_awsize", m_axi_awsize, 3);
    check("const_awburst", m_axi_awburst, 1);
    @(negedge clk);
    rst_n = 1;

    run_xfer(32'h1000, 32'd64, 8'd4, -1, 2'b00, 0, 0);
    run_xfer(32'h0FF0, 32'd64, 8'd16, -1, 2'b00, 0, 0);
    run_xfer(32'h1004, 32'd64, 8'd4, -1, 2'b10, 0, 0);
    run_xfer(32'h1000, 32'd12, 8'd4, -1, 2'b10, 0, 0);
    run_xfer(32'h2000, 32'd0, 8'd4, -1, 2'b00, 0, 0);
    run_xfer(32'h2000, 32'd32, 8'd0, -1, 2'b00, 0, 0);
    run_xfer(32'h2FE8, 32'd256, 8'd255, -1, 2'b00, 30, 20);
    for (int t = 0; t < 6; t++)
      run_xfer(32'h0001_0000 + 32'($urandom_range(0, 511)) * 8, 32'($urandom_range(1, 80)) * 8,
               8'($urandom_range(0, 20)), -1, 2'b00, 40, 30);
    run_xfer(32'h3000, 32'd96, 8'd4, 1, 2'b01, 20, 10);
    run_xfer(32'h3000, 32'd64, 8'd8, -1, 2'b00, 0, 0);

    @(negedge clk);
    stall_pct = 50; gap_pct = 20; err_burst = -1;
    prep(32'h4000, 32'd512, 8'd16, 1, nb);
    dst_addr_i = 32'h4000; len_bytes_i = 32'd512; max_beats_i = 8'd16; start_i = 1;
    @(negedge clk);
    start_i = 0;
    #2;
    for (int c = 0; c < 2000 && !m_axi_wvalid; c++) begin @(negedge clk); #2; end
    check("reached_send_w", m_axi_wvalid, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    #2;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1;
    run_xfer(32'h5000, 32'd80, 8'd4, -1, 2'b00, 30, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
